// File: rtl/cell_exerciser.sv
// cell_exerciser: exhaustive 3-input truth-table tester for up to NSLOT
// externally muxed cells-under-test. Each enabled slot is driven with all
// eight {C,B,A} vectors. Every vector is held SETTLE+1 cycles, and the CUT
// output Y is compared against a snapshotted expected truth table on the
// last hold cycle. The block keeps a saturating error count and a
// first-failure record, and flags PASS at the end of the run.
module cell_exerciser #(
    parameter int NSLOT  = 4,
    parameter int SETTLE = 2,
    parameter int ECW    = 8,
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [NSLOT-1:0]     SLOT_EN,
    input  logic [8*NSLOT-1:0]   TT,
    input  logic                 Y,
    output logic [SW-1:0]        SEL,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [ECW-1:0]       ERRCNT,
    output logic                 FAIL_VALID,
    output logic [SW-1:0]        FAIL_SLOT,
    output logic [2:0]           FAIL_VEC
);

    // Hold counter is sized for the largest supported SETTLE (15).
    localparam int CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Lowest set bit of mask at index >= from.
    // Result MSB = found flag, low SW bits = slot index.
    function automatic logic [SW:0] find_slot(input logic [NSLOT-1:0] mask,
                                              input int from);
        logic [SW:0] res;
        res = {1'b0, {SW{1'b0}}};
        // Scan downward so the lowest qualifying slot is the last one written.
        for (int s = NSLOT - 1; s >= 0; s--) begin
            if ((s >= from) && mask[s]) begin
                res = {1'b1, SW'(s)};
            end
        end
        return res;
    endfunction

    state_t               r_state;
    logic [NSLOT-1:0]     r_mask;
    logic [8*NSLOT-1:0]   r_tt;
    logic [SW-1:0]        r_slot;
    logic [2:0]           r_vec;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [ECW-1:0]       r_errcnt;
    logic                 r_fail_valid;
    logic [SW-1:0]        r_fail_slot;
    logic [2:0]           r_fail_vec;

    logic                 w_exp;
    logic                 w_sample;
    logic                 w_mismatch;
    logic [ECW-1:0]       w_err_next;
    logic [SW:0]          w_first;
    logic [SW:0]          w_next;

    // Slot search from the live mask (run start) and from the snapshot
    // (advance to the next slot above the current one).
    assign w_first = find_slot(SLOT_EN, 0);
    assign w_next  = find_slot(r_mask, int'(r_slot) + 1);

    // Sample qualification, mismatch detection and saturating error count.
    always_comb begin
        w_exp      = r_tt[{r_slot, r_vec}];
        w_sample   = 1'b0;
        w_mismatch = 1'b0;
        w_err_next = r_errcnt;
        if ((r_state == ST_DRIVE) && !ABORT && (r_cnt == CW'(SETTLE))) begin
            w_sample = 1'b1;
        end else begin
            w_sample = 1'b0;
        end
        if (w_sample && (Y != w_exp)) begin
            w_mismatch = 1'b1;
        end else begin
            w_mismatch = 1'b0;
        end
        if (w_mismatch && (r_errcnt != {ECW{1'b1}})) begin
            w_err_next = r_errcnt + ECW'(1);
        end else begin
            w_err_next = r_errcnt;
        end
    end

    // Run controller: state, stimulus, result registers and status pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_mask       <= {NSLOT{1'b0}};
            r_tt         <= {(8*NSLOT){1'b0}};
            r_slot       <= {SW{1'b0}};
            r_vec        <= 3'd0;
            r_cnt        <= {CW{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_errcnt     <= {ECW{1'b0}};
            r_fail_valid <= 1'b0;
            r_fail_slot  <= {SW{1'b0}};
            r_fail_vec   <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_mask       <= SLOT_EN;
                        r_tt         <= TT;
                        r_errcnt     <= {ECW{1'b0}};
                        r_fail_valid <= 1'b0;
                        r_fail_slot  <= {SW{1'b0}};
                        r_fail_vec   <= 3'd0;
                        r_vec        <= 3'd0;
                        r_cnt        <= {CW{1'b0}};
                        if (w_first[SW]) begin
                            r_slot  <= w_first[SW-1:0];
                            r_busy  <= 1'b1;
                            r_pass  <= 1'b0;
                            r_state <= ST_DRIVE;
                        end else begin
                            // Empty mask: nothing to test, finish with a clean result.
                            r_slot  <= {SW{1'b0}};
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_DRIVE: begin
                    if (ABORT) begin
                        // Abort wins over any sample due this cycle.
                        r_slot  <= {SW{1'b0}};
                        r_vec   <= 3'd0;
                        r_cnt   <= {CW{1'b0}};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_errcnt == {ECW{1'b0}});
                        r_state <= ST_FINISH;
                    end else if (w_sample) begin
                        r_errcnt <= w_err_next;
                        if (w_mismatch && !r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_slot  <= r_slot;
                            r_fail_vec   <= r_vec;
                        end
                        r_cnt <= {CW{1'b0}};
                        if (r_vec != 3'd7) begin
                            r_vec <= r_vec + 3'd1;
                        end else if (w_next[SW]) begin
                            // Advance straight into the next slot, no gap cycle.
                            r_slot <= w_next[SW-1:0];
                            r_vec  <= 3'd0;
                        end else begin
                            r_slot  <= {SW{1'b0}};
                            r_vec   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == {ECW{1'b0}});
                            r_state <= ST_FINISH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_FINISH: begin
                    // START here is deliberately not looked at.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_slot  <= {SW{1'b0}};
                    r_vec   <= 3'd0;
                    r_cnt   <= {CW{1'b0}};
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot and vector registers are cleared outside DRIVE,
    // so the stimulus outputs idle at zero.
    assign SEL        = r_slot;
    assign A          = r_vec[0];
    assign B          = r_vec[1];
    assign C          = r_vec[2];
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign PASS       = r_pass;
    assign ERRCNT     = r_errcnt;
    assign FAIL_VALID = r_fail_valid;
    assign FAIL_SLOT  = r_fail_slot;
    assign FAIL_VEC   = r_fail_vec;

endmodule

// File: tb/tb_cell_exerciser.sv
// Testbench for cell_exerciser: directed runs with hand-computed results
// are queued at START and checked by monitors when DONE pulses.
module tb_cell_exerciser;

    localparam int HOLD = 3;   // SETTLE + 1 for the default instance

    typedef struct {
        string      name;
        logic       pass;
        logic [7:0] err;
        logic       fv;
        logic [1:0] fs;
        logic [2:0] fvec;
        int         busy;
        logic [3:0] mask;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0;
    logic [3:0]  slot_en = 4'd0;
    logic [31:0] tt = 32'd0;
    logic        y1, y2;
    logic [1:0]  sel1, sel2, fs1, fs2, err2;
    logic        a1, b1, c1, a2, b2, c2;
    logic        busy1, done1, pass1, fv1, busy2, done2, pass2, fv2;
    logic [7:0]  err1;
    logic [2:0]  fvec1, fvec2;
    logic [1:0]  cut_mode [4];   // 0 NAND3, 1 stuck-0, 2 inverted NAND3

    int n_checks = 0;
    int n_pass   = 0;
    int n_done1  = 0;
    int n_done2  = 0;
    int idle_bad = 0;

    always #5 CLK = ~CLK;

    cell_exerciser #(.NSLOT(4), .SETTLE(2), .ECW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(start1), .ABORT(abort1),
        .SLOT_EN(slot_en), .TT(tt), .Y(y1), .SEL(sel1),
        .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERRCNT(err1), .FAIL_VALID(fv1), .FAIL_SLOT(fs1), .FAIL_VEC(fvec1)
    );

    cell_exerciser #(.NSLOT(4), .SETTLE(2), .ECW(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(start2), .ABORT(1'b0),
        .SLOT_EN(slot_en), .TT(tt), .Y(y2), .SEL(sel2),
        .A(a2), .B(b2), .C(c2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERRCNT(err2), .FAIL_VALID(fv2), .FAIL_SLOT(fs2), .FAIL_VEC(fvec2)
    );

    // CUT models behind the external mux
    always_comb begin
        case (cut_mode[sel1])
            2'd0:    y1 = ~(a1 & b1 & c1);
            2'd1:    y1 = 1'b0;
            2'd2:    y1 = a1 & b1 & c1;
            default: y1 = 1'b1;
        endcase
    end
    assign y2 = a2 & b2 & c2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    function automatic logic [1:0] nth_set(input logic [3:0] m, input int n);
        int c;
        logic [1:0] r;
        c = 0;
        r = 2'd0;
        for (int s = 0; s < 4; s++) begin
            if (m[s]) begin
                if (c == n) r = 2'(s);
                c++;
            end
        end
        return r;
    endfunction

    // Monitor / scoreboard for the default instance
    initial begin
        int busy_cnt;
        int seq_bad;
        exp_t e;
        busy_cnt = 0;
        seq_bad  = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                busy_cnt = 0;
                seq_bad  = 0;
            end else begin
                if (busy1) begin
                    if (q1.size() > 0) begin
                        if (sel1 !== nth_set(q1[0].mask, busy_cnt / (8 * HOLD)) ||
                            {c1, b1, a1} !== 3'((busy_cnt / HOLD) % 8))
                            seq_bad++;
                    end
                    busy_cnt++;
                end else if (sel1 !== 2'd0 || {c1, b1, a1} !== 3'd0) begin
                    idle_bad++;
                end
                if (done1) begin
                    n_done1++;
                    if (q1.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        chk({e.name, ".busy"}, busy_cnt, e.busy);
                        chk({e.name, ".seq"}, seq_bad, 0);
                        chk({e.name, ".pass"}, {31'd0, pass1}, {31'd0, e.pass});
                        chk({e.name, ".errcnt"}, {24'd0, err1}, {24'd0, e.err});
                        chk({e.name, ".fail_valid"}, {31'd0, fv1}, {31'd0, e.fv});
                        if (e.fv) begin
                            chk({e.name, ".fail_slot"}, {30'd0, fs1}, {30'd0, e.fs});
                            chk({e.name, ".fail_vec"}, {29'd0, fvec1}, {29'd0, e.fvec});
                        end
                    end
                    busy_cnt = 0;
                    seq_bad  = 0;
                end
            end
        end
    end

    // Monitor / scoreboard for the ECW=2 instance
    initial begin
        int busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                busy_cnt = 0;
            end else begin
                if (busy2) busy_cnt++;
                else if (sel2 !== 2'd0 || {c2, b2, a2} !== 3'd0) idle_bad++;
                if (done2) begin
                    n_done2++;
                    if (q2.size() == 0) begin
                        chk("unexpected_done2", 32'd1, 32'd0);
                    end else begin
                        e = q2.pop_front();
                        chk({e.name, ".busy"}, busy_cnt, e.busy);
                        chk({e.name, ".pass"}, {31'd0, pass2}, {31'd0, e.pass});
                        chk({e.name, ".errcnt"}, {30'd0, err2}, {24'd0, e.err});
                        chk({e.name, ".fail_valid"}, {31'd0, fv2}, {31'd0, e.fv});
                        chk({e.name, ".fail_slot"}, {30'd0, fs2}, {30'd0, e.fs});
                        chk({e.name, ".fail_vec"}, {29'd0, fvec2}, {29'd0, e.fvec});
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic pulse_start1();
        @(posedge CLK); #1 start1 = 1'b1;
        @(posedge CLK); #1 start1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done1_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_vec1(input logic [2:0] v);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ({c1, b1, a1} == v) break;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, {31'd0, busy1}, 32'd0);
        chk({tag, ".done"}, {31'd0, done1}, 32'd0);
        chk({tag, ".pass"}, {31'd0, pass1}, 32'd0);
        chk({tag, ".errcnt"}, {24'd0, err1}, 32'd0);
        chk({tag, ".fail"}, {26'd0, fv1, fs1, fvec1}, 32'd0);
        chk({tag, ".stim"}, {27'd0, sel1, c1, b1, a1}, 32'd0);
    endtask

    // Directed stimulus
    initial begin
        int done_before;
        for (int s = 0; s < 4; s++) cut_mode[s] = 2'd0;
        repeat (2) @(posedge CLK);
        #1 chk_all_zero("reset");
        RST_N = 1'b1;

        // Single NAND3 slot, all correct; START in the FINISH cycle is ignored
        slot_en = 4'b0001; tt = 32'h0000_007F;
        q1.push_back('{"nand3", 1'b1, 8'd0, 1'b0, 2'd0, 3'd0, 24, 4'b0001});
        pulse_start1();
        wait_done1(60);
        start1 = 1'b1;
        @(posedge CLK); #1 start1 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("start_in_finish_ignored", {31'd0, busy1}, 32'd0);

        // Two slots, slot2 stuck at 0 against TT 0x88; inputs changed mid-run
        slot_en = 4'b0101; tt = 32'h0088_007F; cut_mode[2] = 2'd1;
        q1.push_back('{"two_slot", 1'b0, 8'd2, 1'b1, 2'd2, 3'd3, 48, 4'b0101});
        pulse_start1();
        slot_en = 4'b1111; tt = 32'hFFFF_FFFF;
        wait_done1(100);

        // Empty mask: DONE right after START, clean result
        slot_en = 4'b0000;
        q1.push_back('{"empty", 1'b1, 8'd0, 1'b0, 2'd0, 3'd0, 0, 4'b0000});
        pulse_start1();
        chk("empty.done_next_cycle", {31'd0, done1}, 32'd1);
        @(negedge CLK);

        // Abort in the first cycle of vector 4, every vector mismatching
        slot_en = 4'b0001; tt = 32'h0000_007F; cut_mode[0] = 2'd2;
        q1.push_back('{"abort_v4", 1'b0, 8'd4, 1'b1, 2'd0, 3'd0, 13, 4'b0001});
        pulse_start1();
        wait_vec1(3'd4);
        abort1 = 1'b1;
        @(posedge CLK); #1 abort1 = 1'b0;
        wait_done1(10);

        // Abort coincident with the final sample: final sample discarded
        q1.push_back('{"abort_last", 1'b0, 8'd7, 1'b1, 2'd0, 3'd0, 24, 4'b0001});
        pulse_start1();
        wait_vec1(3'd7);
        @(negedge CLK);
        @(negedge CLK);
        abort1 = 1'b1;
        @(posedge CLK); #1 abort1 = 1'b0;
        wait_done1(10);

        // Reset mid-run: outputs clear at once, no DONE, then fresh run
        pulse_start1();
        repeat (10) @(posedge CLK);
        #1 chk("pre_reset_errcnt", {24'd0, err1}, 32'd3);
        RST_N = 1'b0;
        #1 chk_all_zero("midrun_reset");
        done_before = n_done1;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_no_done", n_done1, done_before);
        cut_mode[0] = 2'd0;
        q1.push_back('{"nand3_after_reset", 1'b1, 8'd0, 1'b0, 2'd0, 3'd0, 24, 4'b0001});
        pulse_start1();
        wait_done1(60);

        // ECW=2 instance: saturating count, START during BUSY ignored
        q2.push_back('{"sat_ecw2", 1'b0, 8'd3, 1'b1, 2'd0, 3'd0, 24, 4'b0001});
        @(posedge CLK); #1 start2 = 1'b1;
        @(posedge CLK); #1 start2 = 1'b0;
        repeat (5) @(posedge CLK);
        #1 start2 = 1'b1;
        @(posedge CLK); #1 start2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done2) break;
        end
        repeat (4) @(negedge CLK);

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("done1_count", n_done1, 6);
        chk("done2_count", n_done2, 1);
        chk("idle_outputs_zero", idle_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cell_exerciser.md
CELL_EXERCISER -- requirements
Module: cell_exerciser

Interface
REQ-001 Parameter NSLOT, default 4: number of cell-under-test (CUT) slots, 2..16.
REQ-002 Parameter SETTLE, default 2: extra hold cycles per vector before sampling, 0..15.
REQ-003 Parameter ECW, default 8: error counter width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, ports named CLK and RST_N.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST_N  input  1  async active-low reset.
REQ-007 START  input  1  run request, sampled in IDLE only.
REQ-008 ABORT  input  1  synchronous run termination.
REQ-009 SLOT_EN  input  NSLOT  slot enable mask.
REQ-010 TT  input  8*NSLOT  expected truth tables; bit TT[8*s+v] is the expected Y of slot s for vector v={C,B,A}.
REQ-011 Y  input  1  CUT output, externally muxed by SEL.
REQ-012 SEL  output  clog2(NSLOT)  selected slot.
REQ-013 A, B, C  output  1 each  CUT stimulus, vector bits 0, 1, 2.
REQ-014 BUSY  output  1  high in DRIVE.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 PASS  output  1  last run had zero errors.
REQ-017 ERRCNT  output  ECW  mismatch count of the last or current run.
REQ-018 FAIL_VALID, FAIL_SLOT (clog2(NSLOT)), FAIL_VEC (3)  outputs  first-mismatch record.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, DRIVE and FINISH.
REQ-020 In IDLE with START=1, the block SHALL snapshot SLOT_EN and TT, clear ERRCNT, FAIL_VALID, FAIL_SLOT, FAIL_VEC and PASS, set vec=0 and cnt=0, and select the lowest enabled slot.
REQ-021 On that START, the next state SHALL be DRIVE, or FINISH if the snapshot mask is zero.
REQ-022 START outside IDLE SHALL be ignored.
REQ-023 Changes to SLOT_EN and TT during a run SHALL have no effect on that run.
REQ-024 In DRIVE, SEL SHALL equal the current slot, {C,B,A} SHALL equal vec, and cnt SHALL increment each cycle from 0 to SETTLE.
REQ-025 In the DRIVE cycle with cnt==SETTLE, Y SHALL be compared to TT[8*slot+vec] at that rising edge.
REQ-026 Each vector SHALL therefore be held for exactly SETTLE+1 cycles.
REQ-027 On a mismatch, ERRCNT SHALL increment, saturating at 2^ECW-1.
REQ-028 On the first mismatch of a run, FAIL_VALID SHALL be set to 1 and FAIL_SLOT/FAIL_VEC SHALL be loaded with the slot and vector; later mismatches SHALL not change them.
REQ-029 After each sample with vec<7, vec SHALL increment and cnt SHALL reset to 0.
REQ-030 After each sample with vec==7, the block SHALL advance to the next higher enabled slot with vec=0, or go to FINISH if no higher slot is enabled.
REQ-031 Slot advance SHALL take no idle cycle.
REQ-032 A run SHALL therefore hold BUSY for exactly popcount(mask)*8*(SETTLE+1) cycles.
REQ-033 ABORT=1 in DRIVE SHALL force FINISH next cycle; no sample SHALL be taken in that cycle.
REQ-034 If ABORT and the final sample coincide, ABORT SHALL win and the final sample SHALL be discarded.
REQ-035 In FINISH, DONE SHALL be 1 for one cycle and PASS SHALL load (ERRCNT==0); the next state SHALL be IDLE.
REQ-036 A START in the FINISH cycle SHALL be ignored.
REQ-037 PASS, ERRCNT and the FAIL_* outputs SHALL hold until the next accepted START.
REQ-038 Outside DRIVE, SEL, A, B and C SHALL be 0.

Reset
REQ-039 While RST_N=0, the state SHALL be IDLE and every output SHALL be 0, including PASS and ERRCNT, asynchronously.
REQ-040 Reset asserted mid-run SHALL discard the run, with no DONE pulse.
REQ-041 The first START after reset release SHALL begin a fresh run.

Verification (bench uses NSLOT=4, SETTLE=2, ECW=8 unless stated)
REQ-042 SLOT_EN=4'b0001, TT[7:0]=8'h7F, CUT model is NAND3 -> BUSY 24 cycles, vectors 0..7 each held 3 cycles, DONE pulse, PASS=1, ERRCNT=0, FAIL_VALID=0.
REQ-043 SLOT_EN=4'b0101, slot0 correct, slot2 TT=8'h88 with Y stuck at 0 -> BUSY 48 cycles, ERRCNT=2, FAIL_SLOT=2, FAIL_VEC=3, PASS=0.
REQ-044 SLOT_EN=0, START -> DONE in the next cycle, BUSY never high, PASS=1, ERRCNT=0.
REQ-045 ABORT in the first cycle of slot0 vector 4 -> DONE the next cycle, ERRCNT counts only vectors 0..3, and the aborted vector is not sampled.
REQ-046 RST_N low during a run -> all outputs 0 immediately with no DONE; after release, START with the REQ-042 setup reproduces the REQ-042 result.
REQ-047 ECW=2, SLOT_EN=4'b0001, Y always inverted -> ERRCNT saturates at 3, FAIL_VEC=0; a START during BUSY is ignored.
